// File: rtl/ocl_axil_reg_frontend.sv
// AXI4-Lite slave front end for the OCL BAR. Turns AW/W/AR handshakes into
// single-cycle register write / read-request strobes for the register block
// and returns its read data on R, answering with SLVERR if it never responds.
//
// Handshake semantics: a transfer happens on the rising edge where both
// valid and ready are high. A master holds valid (and its payload) until
// that edge. This block raises bvalid/rvalid only with a stable payload and
// holds it until the matching ready. Its own ready outputs never depend
// combinationally on the master's valid.
module ocl_axil_reg_frontend #(
  parameter int ADDR_W     = 32,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              clk_main_a0,
  input  logic              rst_main,
  input  logic              awvalid,
  input  logic [ADDR_W-1:0] awaddr,
  output logic              awready,
  input  logic              wvalid,
  input  logic [31:0]       wdata,
  output logic              wready,
  output logic              bvalid,
  output logic [1:0]        bresp,
  input  logic              bready,
  input  logic              arvalid,
  input  logic [ADDR_W-1:0] araddr,
  output logic              arready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  input  logic              rready,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [31:0]       reg_wr_data,
  output logic              reg_rd_req,
  output logic [ADDR_W-1:0] reg_rd_addr,
  input  logic              reg_rd_valid,
  input  logic [31:0]       reg_rd_data
);

  // Clears the byte offset so downstream always sees word addresses.
  localparam logic [ADDR_W-1:0] ALIGN_MASK   = ~ADDR_W'(3);
  localparam logic [7:0]        TIMEOUT_LOAD = 8'(RD_TIMEOUT);

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;

  wr_state_t         w_state, w_state_n;
  rd_state_t         r_state, r_state_n;
  logic              aw_held, aw_held_n;
  logic              w_held, w_held_n;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [7:0]        rd_cnt;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;

  // Readies are registered, so a handshake is valid AND the current ready.
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  assign reg_wr_en   = (w_state == W_ISSUE);
  assign reg_wr_addr = aw_addr_q;
  assign reg_wr_data = w_data_q;
  assign bvalid      = (w_state == W_RESP);
  assign bresp       = 2'b00;
  assign rvalid      = (r_state == R_RESP);

  // Write FSM state and holding-flag registers.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      w_state <= w_state_n;
      aw_held <= aw_held_n;
      w_held  <= w_held_n;
    end
  end

  // Write FSM: collect AW and W in any order, strobe once, then respond on B.
  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) aw_held_n = 1'b1;
        if (w_hs)  w_held_n  = 1'b1;
        if (aw_held_n && w_held_n) w_state_n = W_ISSUE;
      end
      W_ISSUE: begin
        aw_held_n = 1'b0;
        w_held_n  = 1'b0;
        w_state_n = W_RESP;
      end
      W_RESP: begin
        if (bready) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Capture the write address (word aligned) and data on their handshakes.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= awaddr & ALIGN_MASK;
      if (w_hs)  w_data_q  <= wdata;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) r_state <= R_IDLE;
    else          r_state <= r_state_n;
  end

  // Read FSM: wait for register data or the timeout, then hold R until taken.
  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_state_n = R_WAIT;
      R_WAIT: if (reg_rd_valid || (rd_cnt == 8'd1)) r_state_n = R_RESP;
      R_RESP: if (rready) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  // Read datapath: request strobe, held address, timeout counter, R payload.
  // The last WAIT cycle is the one where the counter is 1; valid data seen in
  // that same cycle takes priority over the error response.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      reg_rd_req  <= 1'b0;
      reg_rd_addr <= '0;
      rd_cnt      <= '0;
      rdata       <= '0;
      rresp       <= 2'b00;
    end else begin
      reg_rd_req <= ar_hs;
      if (ar_hs) begin
        reg_rd_addr <= araddr & ALIGN_MASK;
        rd_cnt      <= TIMEOUT_LOAD;
      end
      case (r_state)
        R_WAIT: begin
          rd_cnt <= rd_cnt - 8'd1;
          if (reg_rd_valid) begin
            rdata <= reg_rd_data;
            rresp <= 2'b00;
          end else if (rd_cnt == 8'd1) begin
            rdata <= 32'hdeaddead;
            rresp <= 2'b10;
          end
        end
        R_RESP: begin
          if (rready) begin
            rdata <= '0;
            rresp <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  // Ready outputs are registered from the next state so they are glitch
  // free and stay low while reset is asserted.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      arready <= 1'b0;
    end else begin
      awready <= (w_state_n == W_IDLE) && !aw_held_n;
      wready  <= (w_state_n == W_IDLE) && !w_held_n;
      arready <= (r_state_n == R_IDLE);
    end
  end

endmodule

// File: tb/tb_ocl_axil_reg_frontend.sv
// Bench for ocl_axil_reg_frontend: directed AXI-Lite write/read scenarios,
// a transaction-level timing model checked every cycle, and literal pins.
module tb_ocl_axil_reg_frontend;

  localparam int ADDR_W     = 32;
  localparam int RD_TIMEOUT = 16;

  logic              clk_main_a0 = 1'b0;
  logic              rst_main;
  logic              awvalid, wvalid, bready, arvalid, rready, reg_rd_valid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [31:0]       wdata, reg_rd_data;
  logic              awready, wready, bvalid, arready, rvalid;
  logic              reg_wr_en, reg_rd_req;
  logic [1:0]        bresp, rresp;
  logic [31:0]       rdata, reg_wr_data;
  logic [ADDR_W-1:0] reg_wr_addr, reg_rd_addr;

  ocl_axil_reg_frontend #(.ADDR_W(ADDR_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk_main_a0(clk_main_a0), .rst_main(rst_main),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr),
    .reg_rd_valid(reg_rd_valid), .reg_rd_data(reg_rd_data)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk_main_a0 = ~clk_main_a0;

  int cyc = 0;
  always @(posedge clk_main_a0) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not end, cyc=%0d required <40000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void chk1(string nm, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endfunction

  // ---------------- transaction model state ----------------
  // Write side: which halves are in hand, the cycle the strobe is due, and
  // whether a B response is outstanding. Read side: cycle of the accepted AR
  // (the timeout deadline is derived from it) and the pending R payload.
  bit          m_ready_en;
  bit          m_aw_have, m_w_have, m_b_pend;
  logic [31:0] m_aw_addr, m_w_data;
  int          m_wr_strobe;
  int          m_rd_issue;
  logic [31:0] m_rd_addr;
  bit          m_r_pend;
  logic [31:0] m_r_data;
  logic [1:0]  m_r_resp;

  // observations used by the directed literal checks
  int          mon_wr_cnt = 0, mon_wr_cyc = -1, mon_b_cyc = -1, b_done = 0;
  logic [31:0] mon_wr_addr, mon_wr_data;
  int          mon_rq_cyc = -1, mon_r_cyc = -1, r_done = 0;
  logic [31:0] mon_rq_addr, mon_r_data;
  logic [1:0]  mon_r_resp;
  bit          b_prev, r_prev;

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk_main_a0) begin : cmp
    logic e_collect, e_awr, e_wr, e_arr, e_wen, e_wait, e_rq;
    if (rst_main) begin
      chk("rst_ctrl", 32'({awready, wready, arready, bvalid, rvalid, reg_wr_en, reg_rd_req}), 32'h0);
      chk("rst_resp", 32'({bresp, rresp}), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_rd_addr", reg_rd_addr, 32'h0);
      chk("rst_wr_addr", reg_wr_addr, 32'h0);
      chk("rst_wr_data", reg_wr_data, 32'h0);
      m_ready_en = 0; m_aw_have = 0; m_w_have = 0; m_b_pend = 0;
      m_wr_strobe = -1; m_rd_issue = -1; m_r_pend = 0;
      b_prev = 0; r_prev = 0;
    end else begin
      e_collect = (m_wr_strobe < 0) && !m_b_pend;
      e_awr  = m_ready_en && e_collect && !m_aw_have;
      e_wr   = m_ready_en && e_collect && !m_w_have;
      e_arr  = m_ready_en && (m_rd_issue < 0) && !m_r_pend;
      e_wen  = (m_wr_strobe == cyc);
      e_wait = (m_rd_issue >= 0);
      e_rq   = e_wait && (cyc == m_rd_issue + 1);

      chk1("awready", awready, e_awr);
      chk1("wready", wready, e_wr);
      chk1("arready", arready, e_arr);
      chk1("reg_wr_en", reg_wr_en, e_wen);
      if (e_wen) begin
        chk("reg_wr_addr", reg_wr_addr, m_aw_addr);
        chk("reg_wr_data", reg_wr_data, m_w_data);
      end
      chk1("bvalid", bvalid, m_b_pend);
      chk("bresp", 32'(bresp), 32'h0);
      chk1("reg_rd_req", reg_rd_req, e_rq);
      if (e_wait || m_r_pend) chk("reg_rd_addr", reg_rd_addr, m_rd_addr);
      chk1("rvalid", rvalid, m_r_pend);
      chk("rdata", rdata, m_r_pend ? m_r_data : 32'h0);
      chk("rresp", 32'(rresp), m_r_pend ? 32'(m_r_resp) : 32'h0);

      // observations
      if (reg_wr_en) begin
        mon_wr_cnt++; mon_wr_cyc = cyc; mon_wr_addr = reg_wr_addr; mon_wr_data = reg_wr_data;
      end
      if (bvalid && !b_prev) mon_b_cyc = cyc;
      if (bvalid && bready) b_done++;
      if (reg_rd_req) begin mon_rq_cyc = cyc; mon_rq_addr = reg_rd_addr; end
      if (rvalid && !r_prev) begin mon_r_cyc = cyc; mon_r_data = rdata; mon_r_resp = rresp; end
      if (rvalid && rready) r_done++;
      b_prev = bvalid; r_prev = rvalid;

      // advance the write model
      if (m_b_pend && bready) m_b_pend = 0;
      if (e_wen) begin
        m_wr_strobe = -1; m_aw_have = 0; m_w_have = 0; m_b_pend = 1;
      end
      if (e_awr && awvalid) begin m_aw_have = 1; m_aw_addr = {awaddr[31:2], 2'b00}; end
      if (e_wr && wvalid) begin m_w_have = 1; m_w_data = wdata; end
      if (e_collect && m_aw_have && m_w_have) m_wr_strobe = cyc + 1;

      // advance the read model: data beats the deadline in the last cycle
      if (m_r_pend) begin
        if (rready) m_r_pend = 0;
      end else if (e_wait) begin
        if (reg_rd_valid) begin
          m_r_pend = 1; m_r_data = reg_rd_data; m_r_resp = 2'b00; m_rd_issue = -1;
        end else if (cyc == m_rd_issue + RD_TIMEOUT) begin
          m_r_pend = 1; m_r_data = 32'hdeaddead; m_r_resp = 2'b10; m_rd_issue = -1;
        end
      end
      if (e_arr && arvalid) begin m_rd_issue = cyc; m_rd_addr = {araddr[31:2], 2'b00}; end
      m_ready_en = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic aw_send(input logic [31:0] a, output int hs);
    bit ok = 0;
    hs = -1;
    awvalid = 1'b1; awaddr = a;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk_main_a0);
      if (awready) begin ok = 1; hs = cyc; end
    end
    chk1("aw_accept", ok, 1'b1);
    @(posedge clk_main_a0); #1;
    awvalid = 1'b0; awaddr = '0;
  endtask

  task automatic w_send(input logic [31:0] d, output int hs);
    bit ok = 0;
    hs = -1;
    wvalid = 1'b1; wdata = d;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk_main_a0);
      if (wready) begin ok = 1; hs = cyc; end
    end
    chk1("w_accept", ok, 1'b1);
    @(posedge clk_main_a0); #1;
    wvalid = 1'b0; wdata = '0;
  endtask

  task automatic ar_send(input logic [31:0] a, output int hs);
    bit ok = 0;
    hs = -1;
    arvalid = 1'b1; araddr = a;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk_main_a0);
      if (arready) begin ok = 1; hs = cyc; end
    end
    chk1("ar_accept", ok, 1'b1);
    @(posedge clk_main_a0); #1;
    arvalid = 1'b0; araddr = '0;
  endtask

  task automatic rd_pulse(input logic [31:0] d);
    reg_rd_valid = 1'b1; reg_rd_data = d;
    @(posedge clk_main_a0); #1;
    reg_rd_valid = 1'b0; reg_rd_data = '0;
  endtask

  task automatic wait_b(input int target);
    bit ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(posedge clk_main_a0);
      if (b_done >= target) ok = 1;
    end
    #1;
    chk1("b_handshake", ok, 1'b1);
  endtask

  task automatic wait_r(input int target);
    bit ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(posedge clk_main_a0);
      if (r_done >= target) ok = 1;
    end
    #1;
    chk1("r_handshake", ok, 1'b1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_main_a0);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int h1, h2, h3, n0;
    rst_main = 1'b1;
    awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; bready = 0;
    arvalid = 0; araddr = 0; rready = 0; reg_rd_valid = 0; reg_rd_data = 0;
    cycles(3);
    rst_main = 1'b0;
    cycles(2);

    // T1: AW and W together; strobe one cycle later, B the cycle after
    bready = 1'b1;
    n0 = b_done;
    fork
      aw_send(32'h500, h1);
      w_send(32'hdeadbeef, h2);
    join
    wait_b(n0 + 1);
    chk("t1_same_cycle_hs", 32'(h2 - h1), 32'd0);
    chk("t1_wr_addr", mon_wr_addr, 32'h500);
    chk("t1_wr_data", mon_wr_data, 32'hdeadbeef);
    chk("t1_wr_latency", 32'(mon_wr_cyc - h1), 32'd1);
    chk("t1_b_latency", 32'(mon_b_cyc - h1), 32'd2);

    // T2: W three cycles before AW, B held off for five cycles
    bready = 1'b0;
    n0 = mon_wr_cnt;
    w_send(32'h1, h2);
    chk1("t2_wready_low", wready, 1'b0);
    cycles(2);
    aw_send(32'h508, h1);
    chk("t2_w_to_aw", 32'(h1 - h2), 32'd3);
    cycles(6);
    chk1("t2_bvalid_held", bvalid, 1'b1);
    chk("t2_one_strobe", 32'(mon_wr_cnt - n0), 32'd1);
    chk("t2_wr_addr", mon_wr_addr, 32'h508);
    chk("t2_wr_data", mon_wr_data, 32'h1);
    n0 = b_done;
    bready = 1'b1;
    wait_b(n0 + 1);

    // T3: read answered two cycles after the request, R held off three cycles
    rready = 1'b0;
    n0 = r_done;
    ar_send(32'h504, h3);
    cycles(2);
    rd_pulse(32'h0000_00a5);
    cycles(3);
    rready = 1'b1;
    wait_r(n0 + 1);
    chk("t3_rq_addr", mon_rq_addr, 32'h504);
    chk("t3_rq_latency", 32'(mon_rq_cyc - h3), 32'd1);
    chk("t3_r_latency", 32'(mon_r_cyc - mon_rq_cyc), 32'd3);
    chk("t3_rdata", mon_r_data, 32'h0000_00a5);
    chk("t3_rresp", 32'(mon_r_resp), 32'd0);

    // T4: no register response, timeout SLVERR
    n0 = r_done;
    ar_send(32'h50c, h3);
    wait_r(n0 + 1);
    chk("t4_timeout_latency", 32'(mon_r_cyc - mon_rq_cyc), 32'd16);
    chk("t4_rdata", mon_r_data, 32'hdeaddead);
    chk("t4_rresp", 32'(mon_r_resp), 32'd2);

    // T5: stray reg_rd_valid while idle, then read and write together
    rd_pulse(32'h0000_0bad);
    cycles(1);
    n0 = b_done;
    h1 = r_done;
    fork
      aw_send(32'h503, h1);
      w_send(32'h1234_5678, h2);
      ar_send(32'h600, h3);
    join
    rd_pulse(32'h77);
    wait_b(n0 + 1);
    wait_r(1 + r_done - 1);
    cycles(2);
    chk("t5_wr_addr", mon_wr_addr, 32'h500);
    chk("t5_wr_data", mon_wr_data, 32'h1234_5678);
    chk("t5_wr_latency", 32'(mon_wr_cyc - h1), 32'd1);
    chk("t5_rq_latency", 32'(mon_rq_cyc - h3), 32'd1);
    chk("t5_rq_addr", mon_rq_addr, 32'h600);
    chk("t5_rdata", mon_r_data, 32'h77);
    chk("t5_r_latency", 32'(mon_r_cyc - mon_rq_cyc), 32'd1);

    // T6: reset while a read waits and an AW is held
    aw_send(32'h800, h1);
    ar_send(32'h700, h3);
    cycles(3);
    rst_main = 1'b1;
    #1;
    chk("t6_rst_rd_addr", reg_rd_addr, 32'h0);
    chk1("t6_rst_awready", awready, 1'b0);
    cycles(2);
    rst_main = 1'b0;
    cycles(25);
    n0 = mon_wr_cnt;
    w_send(32'h9, h2);
    cycles(3);
    chk("t6_no_stale_write", 32'(mon_wr_cnt - n0), 32'd0);
    n0 = b_done;
    aw_send(32'h80c, h1);
    wait_b(n0 + 1);
    chk("t6_wr_addr", mon_wr_addr, 32'h80c);
    chk("t6_wr_data", mon_wr_data, 32'h9);

    // T7: reset while R is pending, then a normal read
    rready = 1'b0;
    ar_send(32'h704, h3);
    rd_pulse(32'h11);
    chk1("t7_rvalid_up", rvalid, 1'b1);
    rst_main = 1'b1;
    #1;
    chk1("t7_rst_rvalid", rvalid, 1'b0);
    chk("t7_rst_rdata", rdata, 32'h0);
    cycles(2);
    rst_main = 1'b0;
    cycles(3);
    rready = 1'b1;
    n0 = r_done;
    ar_send(32'h708, h3);
    rd_pulse(32'h5a);
    wait_r(n0 + 1);
    cycles(2);
    chk("t7_rdata", mon_r_data, 32'h5a);
    chk("t7_rq_addr", mon_rq_addr, 32'h708);
    chk("t7_one_response", 32'(r_done - n0), 32'd1);

    cycles(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
